// File: rtl/fetch_unit.sv
// Two-wide instruction fetch stage: owns the fetch PC, issues aligned 64-bit
// icache requests, and buffers returned instruction pairs for decode.
module fetch_unit #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          FB_DEPTH        = 4,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] icache_addr,
    output logic        icache_re,
    input  logic        icache_stall,
    input  logic [63:0] icache_dout,
    input  logic        icache_dout_val,
    input  logic        redirect_val,
    input  logic [31:0] redirect_pc,
    output logic [1:0]  fb_valid,
    output logic [31:0] fb_pc,
    output logic [31:0] fb_instr0,
    output logic [31:0] fb_instr1,
    input  logic        decode_ready
);
    localparam int FB_AW = $clog2(FB_DEPTH);
    localparam int FB_CW = FB_AW + 1;
    localparam int OC_W  = $clog2(MAX_OUTSTANDING + 1);
    localparam int TG_AW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    localparam logic [TG_AW-1:0] TG_LAST = TG_AW'(MAX_OUTSTANDING - 1);
    localparam logic [TG_AW-1:0] TG_ONE  = TG_AW'(1);
    localparam logic [OC_W-1:0]  OC_MAX  = OC_W'(MAX_OUTSTANDING);
    localparam logic [OC_W-1:0]  OC_ONE  = OC_W'(1);
    localparam logic [FB_AW-1:0] FB_ONE  = FB_AW'(1);
    localparam logic [FB_CW:0]   FB_LIM  = (FB_CW + 1)'(FB_DEPTH);

    logic [28:0]      pc_hi;
    logic             pc_skip;
    logic [OC_W-1:0]  out_cnt;
    logic [OC_W-1:0]  discard_cnt;

    logic [TG_AW-1:0] tag_wr;
    logic [TG_AW-1:0] tag_rd;
    logic [28:0]      tag_base [MAX_OUTSTANDING];
    logic [1:0]       tag_mask [MAX_OUTSTANDING];

    logic [FB_AW-1:0] fb_wr;
    logic [FB_AW-1:0] fb_rd;
    logic [FB_CW-1:0] fb_cnt;
    logic [28:0]      fb_base [FB_DEPTH];
    logic [63:0]      fb_data [FB_DEPTH];
    logic [1:0]       fb_mask [FB_DEPTH];

    logic             accept;
    logic             push;
    logic             pop;
    logic             fb_empty;
    logic [FB_CW:0]   credit_used;
    logic             unused;

    assign unused = &{1'b0, redirect_pc[1:0]};

    // Every buffered pair plus every in-flight request holds one buffer slot,
    // so a returning response always has room.
    assign credit_used = {1'b0, fb_cnt} + (FB_CW + 1)'(out_cnt);

    // rst gates the request so nothing is issued while reset is asserted.
    assign icache_re   = rst && !redirect_val && (out_cnt < OC_MAX) && (credit_used < FB_LIM);
    assign icache_addr = {pc_hi, 3'b000};
    assign accept      = icache_re && !icache_stall;

    assign fb_empty = (fb_cnt == '0);
    assign push     = icache_dout_val && (discard_cnt == '0) && !redirect_val;
    assign pop      = !fb_empty && decode_ready && !redirect_val;

    assign fb_valid  = fb_empty ? 2'b00 : fb_mask[fb_rd];
    assign fb_pc     = {fb_base[fb_rd], 3'b000};
    assign fb_instr0 = fb_data[fb_rd][31:0];
    assign fb_instr1 = fb_data[fb_rd][63:32];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_hi       <= RESET_PC[31:3];
            pc_skip     <= RESET_PC[2];
            out_cnt     <= '0;
            discard_cnt <= '0;
            tag_wr      <= '0;
            tag_rd      <= '0;
            fb_wr       <= '0;
            fb_rd       <= '0;
            fb_cnt      <= '0;
        end else begin
            out_cnt <= out_cnt + OC_W'(accept) - OC_W'(icache_dout_val);

            if (accept)
                tag_wr <= (tag_wr == TG_LAST) ? '0 : tag_wr + TG_ONE;
            if (icache_dout_val)
                tag_rd <= (tag_rd == TG_LAST) ? '0 : tag_rd + TG_ONE;

            if (redirect_val) begin
                pc_hi       <= redirect_pc[31:3];
                pc_skip     <= redirect_pc[2];
                // Whatever is still in flight after this cycle belongs to the old path.
                discard_cnt <= out_cnt - OC_W'(icache_dout_val);
                fb_wr       <= '0;
                fb_rd       <= '0;
                fb_cnt      <= '0;
            end else begin
                if (accept) begin
                    pc_hi   <= pc_hi + 29'd1;
                    pc_skip <= 1'b0;
                end
                if (icache_dout_val && discard_cnt != '0)
                    discard_cnt <= discard_cnt - OC_ONE;
                if (push)
                    fb_wr <= fb_wr + FB_ONE;
                if (pop)
                    fb_rd <= fb_rd + FB_ONE;
                fb_cnt <= fb_cnt + FB_CW'(push) - FB_CW'(pop);
            end
        end
    end

    // NOTE: storage arrays carry no reset; their contents are only ever read
    // behind the pointers and counts, which are reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            tag_base[tag_wr] <= pc_hi;
            tag_mask[tag_wr] <= pc_skip ? 2'b10 : 2'b11;
        end
        if (push) begin
            fb_base[fb_wr] <= tag_base[tag_rd];
            fb_mask[fb_wr] <= tag_mask[tag_rd];
            fb_data[fb_wr] <= icache_dout;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: in-order icache model with optional hold,
// walking through streaming, stall, backpressure, redirect and reset cases.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] icache_addr;
    logic        icache_re;
    logic        icache_stall;
    logic [63:0] icache_dout;
    logic        icache_dout_val;
    logic        redirect_val;
    logic [31:0] redirect_pc;
    logic [1:0]  fb_valid;
    logic [31:0] fb_pc;
    logic [31:0] fb_instr0;
    logic [31:0] fb_instr1;
    logic        decode_ready;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] pend[$];
    bit          mem_hold;
    logic [31:0] exp_pc;

    fetch_unit #(
        .RESET_PC(32'h0000_0000),
        .FB_DEPTH(4),
        .MAX_OUTSTANDING(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .icache_addr(icache_addr),
        .icache_re(icache_re),
        .icache_stall(icache_stall),
        .icache_dout(icache_dout),
        .icache_dout_val(icache_dout_val),
        .redirect_val(redirect_val),
        .redirect_pc(redirect_pc),
        .fb_valid(fb_valid),
        .fb_pc(fb_pc),
        .fb_instr0(fb_instr0),
        .fb_instr1(fb_instr1),
        .decode_ready(decode_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ins(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One clock: note this cycle's accepted request, then after the edge
    // present the oldest pending response unless the memory is holding.
    task automatic step();
        logic        acc;
        logic [31:0] a;
        #1;
        acc = icache_re && !icache_stall;
        a   = icache_addr;
        @(posedge clk);
        #1;
        if (acc) pend.push_back(a);
        if (!mem_hold && pend.size() > 0) begin
            a = pend.pop_front();
            icache_dout     = {ins(a + 32'd4), ins(a)};
            icache_dout_val = 1'b1;
        end else begin
            icache_dout     = '0;
            icache_dout_val = 1'b0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst             = 1'b0;
        icache_stall    = 1'b0;
        icache_dout     = '0;
        icache_dout_val = 1'b0;
        redirect_val    = 1'b0;
        redirect_pc     = '0;
        decode_ready    = 1'b1;
        mem_hold        = 1'b0;

        #2;
        check("rst_re", icache_re, 32'd0);
        check("rst_fbv", fb_valid, 32'd0);
        #10;
        rst = 1'b1;
        #1;
        check("c0_addr", icache_addr, 32'h0);
        check("c0_re", icache_re, 32'd1);

        // Streaming with 1-cycle memory latency.
        step();
        check("c1_fbv", fb_valid, 32'd0);
        check("c1_addr", icache_addr, 32'h8);
        step();
        check("c2_fbv", fb_valid, 32'd3);
        check("c2_pc", fb_pc, 32'h0);
        check("c2_i0", fb_instr0, ins(32'h0));
        check("c2_i1", fb_instr1, ins(32'h4));
        check("c2_addr", icache_addr, 32'h10);
        step();
        check("c3_pc", fb_pc, 32'h8);
        check("c3_addr", icache_addr, 32'h18);
        step();
        check("c4_pc", fb_pc, 32'h10);
        check("c4_addr", icache_addr, 32'h20);

        // Five stalled cycles on 0x20.
        icache_stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("stall_addr", icache_addr, 32'h20);
            check("stall_re", icache_re, 32'd1);
            step();
        end
        icache_stall = 1'b0;
        check("c9_addr", icache_addr, 32'h20);
        step();
        check("c10_addr", icache_addr, 32'h28);
        check("c10_fbv", fb_valid, 32'd0);
        step();
        check("c11_pc", fb_pc, 32'h20);
        check("c11_fbv", fb_valid, 32'd3);
        check("c11_addr", icache_addr, 32'h30);

        // Decode backpressure fills the buffer and stops requests.
        decode_ready = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check("bp_re", icache_re, 32'd0);
        check("bp_pc", fb_pc, 32'h20);
        check("bp_fbv", fb_valid, 32'd3);
        decode_ready = 1'b1;
        exp_pc = 32'h20;
        for (int i = 0; i < 5; i++) begin
            step();
            exp_pc = exp_pc + 32'd8;
            check("drain_pc", fb_pc, exp_pc);
            check("drain_fbv", fb_valid, 32'd3);
        end
        check("drain_i1", fb_instr1, ins(32'h4C));

        // Build two buffered pairs with two requests held in flight.
        decode_ready = 1'b0;
        mem_hold     = 1'b1;
        step();
        check("c21_re", icache_re, 32'd0);
        check("c21_pc", fb_pc, 32'h48);
        decode_ready = 1'b1;
        step();
        check("c22_re", icache_re, 32'd1);
        check("c22_addr", icache_addr, 32'h68);
        check("c22_pc", fb_pc, 32'h50);
        decode_ready = 1'b0;
        step();
        check("c23_re", icache_re, 32'd0);
        check("c23_pc", fb_pc, 32'h50);

        // Redirect to 0x104: buffer flushed, both stale responses dropped.
        redirect_val = 1'b1;
        redirect_pc  = 32'h104;
        step();
        redirect_val = 1'b0;
        check("rd1_fbv", fb_valid, 32'd0);
        check("rd1_re", icache_re, 32'd0);
        mem_hold = 1'b0;
        step();
        check("rd1_stale0", fb_valid, 32'd0);
        step();
        check("rd1_addr", icache_addr, 32'h100);
        check("rd1_re2", icache_re, 32'd1);
        check("rd1_stale1", fb_valid, 32'd0);
        step();
        check("rd1_lat", fb_valid, 32'd0);
        step();
        check("rd1_first_fbv", fb_valid, 32'd2);
        check("rd1_first_pc", fb_pc, 32'h100);
        check("rd1_first_i1", fb_instr1, ins(32'h104));

        // Redirect in the same cycle a response arrives.
        decode_ready = 1'b1;
        mem_hold     = 1'b1;
        step();
        check("c29_pc", fb_pc, 32'h108);
        check("c29_fbv", fb_valid, 32'd3);
        step();
        check("c30_fbv", fb_valid, 32'd0);
        check("c30_re", icache_re, 32'd0);
        mem_hold = 1'b0;
        step();
        check("c31_fbv", fb_valid, 32'd0);
        redirect_val = 1'b1;
        redirect_pc  = 32'h300;
        #1;
        check("rd2_re", icache_re, 32'd0);
        step();
        redirect_val = 1'b0;
        #1;
        check("rd2_addr", icache_addr, 32'h300);
        check("rd2_re1", icache_re, 32'd1);
        check("rd2_stale0", fb_valid, 32'd0);
        step();
        check("rd2_stale1", fb_valid, 32'd0);
        step();
        check("rd2_first_fbv", fb_valid, 32'd3);
        check("rd2_first_pc", fb_pc, 32'h300);
        check("rd2_first_i0", fb_instr0, ins(32'h300));

        // Reset mid-stream with two requests in flight and one pair buffered.
        mem_hold = 1'b1;
        step();
        decode_ready = 1'b0;
        step();
        check("pre_rst_pc", fb_pc, 32'h308);
        check("pre_rst_re", icache_re, 32'd0);
        #2;
        rst = 1'b0;
        pend.delete();
        icache_dout_val = 1'b0;
        icache_dout     = '0;
        mem_hold        = 1'b0;
        #1;
        check("mid_rst_re", icache_re, 32'd0);
        check("mid_rst_fbv", fb_valid, 32'd0);
        @(posedge clk);
        #2;
        rst          = 1'b1;
        decode_ready = 1'b1;
        #1;
        check("post_rst_addr", icache_addr, 32'h0);
        check("post_rst_re", icache_re, 32'd1);
        step();
        check("post_rst_addr1", icache_addr, 32'h8);
        check("post_rst_fbv0", fb_valid, 32'd0);
        step();
        check("post_rst_fbv", fb_valid, 32'd3);
        check("post_rst_pc", fb_pc, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
